morse_sequencer: RTL and testbench

- Timing controller for the Morse display path.
- Accepts one letter code (symbol count plus dot/dash pattern) through a valid/ready handshake and drives the LED with standard Morse unit timing: dot 1 unit, dash 3 units, intra-letter gap 1 unit, letter gap 3 units.
- Replaces the fixed-tick shift/display loop; sits between the letter encoder and the LED pin.

---
 rtl/morse_sequencer.sv | 119 +++++++++++
 tb/tb_morse_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/morse_sequencer.sv
// Morse unit-timing sequencer: plays one latched letter code on led_o with dot/dash/gap timing.
// Optional MORSE_WORD_GAP_EN: code_eow stretches the trailing letter gap to a 7-unit word gap.
module morse_sequencer #(
  parameter int TICK_DIV = 25000000,
  parameter int MAX_LEN  = 5
) (
  input  logic               CLOCK_50,
  input  logic               rst,
  input  logic               code_valid,
  output logic               code_ready,
  input  logic [2:0]         code_len,
  input  logic [MAX_LEN-1:0] code_bits,
  input  logic               code_eow,
  output logic               led_o,
  output logic               busy_o,
  output logic               err_o,
  output logic [2:0]         state_o
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W  = $clog2(MAX_LEN) + 1;
`ifdef MORSE_WORD_GAP_EN
  localparam int UNIT_W = 3;
`else
  localparam int UNIT_W = 2;
`endif

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] MARK  = 3'd1;
  localparam logic [2:0] SPACE = 3'd2;
  localparam logic [2:0] LGAP  = 3'd3;

  logic [2:0]         state, next_state;
  logic [TICK_W-1:0]  tick_cnt;
  logic [UNIT_W-1:0]  unit_cnt;
  logic [IDX_W-1:0]   sym_idx;
  logic [2:0]         len_q;
  logic [MAX_LEN-1:0] bits_q;
  logic [MAX_LEN-1:0] bits_shift;
  logic               eow_q;
  logic               transfer, len_ok, unit_end, cur_dash, last_sym;
  logic               mark_done, gap_done;
  logic [UNIT_W-1:0]  gap_last;

  assign code_ready = (state == IDLE);
  assign busy_o     = (state != IDLE);
  assign state_o    = state;

  assign transfer   = code_valid && code_ready;
  assign len_ok     = (code_len != 3'd0) && (int'(code_len) <= MAX_LEN);
  assign unit_end   = (tick_cnt == TICK_W'(TICK_DIV - 1));
  assign bits_shift = bits_q >> sym_idx;
  assign cur_dash   = bits_shift[0];
  assign last_sym   = (int'(sym_idx) + 1 == int'(len_q));
  assign mark_done  = unit_end && (unit_cnt == (cur_dash ? UNIT_W'(2) : UNIT_W'(0)));

`ifdef MORSE_WORD_GAP_EN
  assign gap_last = eow_q ? UNIT_W'(6) : UNIT_W'(2);
`else
  logic unused_eow;
  assign unused_eow = code_eow ^ eow_q;
  assign gap_last   = UNIT_W'(2);
`endif
  assign gap_done = unit_end && (unit_cnt == gap_last);

  // NOTE: always_comb assigns next_state a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (transfer && len_ok) next_state = MARK;
      MARK:    if (mark_done) next_state = last_sym ? LGAP : SPACE;
      SPACE:   if (unit_end) next_state = MARK;
      LGAP:    if (gap_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      led_o    <= 1'b0;
      err_o    <= 1'b0;
      tick_cnt <= '0;
      unit_cnt <= '0;
      sym_idx  <= '0;
      len_q    <= '0;
      bits_q   <= '0;
      eow_q    <= 1'b0;
    end else begin
      state <= next_state;
      led_o <= (next_state == MARK);
      err_o <= transfer && !len_ok;

      if (transfer) begin
        len_q   <= code_len;
        bits_q  <= code_bits;
`ifdef MORSE_WORD_GAP_EN
        eow_q   <= code_eow;
`endif
        sym_idx <= '0;
      end else if (state == SPACE && next_state == MARK) begin
        sym_idx <= sym_idx + 1'b1;
      end

      // Timer restarts on every state change so each state is measured from its first cycle.
      if (transfer || next_state != state || state == IDLE) begin
        tick_cnt <= '0;
        unit_cnt <= '0;
      end else if (unit_end) begin
        tick_cnt <= '0;
        unit_cnt <= unit_cnt + 1'b1;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_morse_sequencer.sv
// Self-checking bench for morse_sequencer: directed letters, illegal lengths, reset abort and random letters.
// Expected behaviour comes from a per-cycle timeline built from the Morse unit rules.
module tb_morse_sequencer;

  localparam int TD = 4;
  localparam int ML = 5;

  logic          CLOCK_50 = 1'b0;
  logic          rst = 1'b1;
  logic          code_valid = 1'b0;
  logic          code_ready;
  logic [2:0]    code_len = '0;
  logic [ML-1:0] code_bits = '0;
  logic          code_eow = 1'b0;
  logic          led_o, busy_o, err_o;
  logic [2:0]    state_o;

  int n_pass  = 0;
  int n_total = 0;
  int exp_q[$];

  morse_sequencer #(.TICK_DIV(TD), .MAX_LEN(ML)) dut (
    .CLOCK_50  (CLOCK_50),
    .rst       (rst),
    .code_valid(code_valid),
    .code_ready(code_ready),
    .code_len  (code_len),
    .code_bits (code_bits),
    .code_eow  (code_eow),
    .led_o     (led_o),
    .busy_o    (busy_o),
    .err_o     (err_o),
    .state_o   (state_o)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
  endtask

  // Timeline of expected state codes, one entry per cycle after the transfer edge.
  task automatic build(input int len, input logic [ML-1:0] bits, input logic eow);
    int gap;
    exp_q.delete();
    for (int s = 0; s < len; s++) begin
      repeat ((bits[s] ? 3 : 1) * TD) exp_q.push_back(1);
      if (s < len - 1) repeat (TD) exp_q.push_back(2);
    end
    gap = 3;
`ifdef MORSE_WORD_GAP_EN
    if (eow) gap = 7;
`endif
    repeat (gap * TD) exp_q.push_back(3);
  endtask

  task automatic check_cycle(input string tag, input int es);
    check({tag, " state"}, 32'(state_o), 32'(es));
    check({tag, " led"},   32'(led_o),   32'(es == 1));
    check({tag, " ready"}, 32'(code_ready), 32'(es == 0));
    check({tag, " busy"},  32'(busy_o),  32'(es != 0));
    check({tag, " err"},   32'(err_o),   32'd0);
  endtask

  // Called at a negedge while IDLE; returns at the negedge of the first IDLE cycle after the letter.
  task automatic play(input string tag, input int len, input logic [ML-1:0] bits,
                      input logic eow, input bit hold);
    build(len, bits, eow);
    if (!hold) begin
      code_len   = 3'(len);
      code_bits  = bits;
      code_eow   = eow;
      code_valid = 1'b1;
    end
    @(posedge CLOCK_50);
    foreach (exp_q[i]) begin
      @(negedge CLOCK_50);
      if (i == 0 && !hold) begin
        code_valid = 1'b0;
        code_len   = 3'($urandom);
        code_bits  = ML'($urandom);
        code_eow   = 1'($urandom);
      end
      check_cycle(tag, exp_q[i]);
    end
    @(negedge CLOCK_50);
    check_cycle({tag, " end"}, 0);
  endtask

  initial begin
    int len;
    logic [ML-1:0] bits;
    logic eow;
    int bad_len[3] = '{0, 6, 7};

    #2 rst = 1'b0;
    #1;
    check("reset led",   32'(led_o), 32'd0);
    check("reset ready", 32'(code_ready), 32'd1);
    check("reset busy",  32'(busy_o), 32'd0);
    check("reset err",   32'(err_o), 32'd0);
    check("reset state", 32'(state_o), 32'd0);
    @(negedge CLOCK_50);
    rst = 1'b1;
    @(negedge CLOCK_50);

    play("A", 2, 5'b00010, 1'b0, 1'b0);
    play("E", 1, 5'b00000, 1'b0, 1'b0);

    foreach (bad_len[k]) begin
      code_len   = 3'(bad_len[k]);
      code_bits  = ML'($urandom);
      code_valid = 1'b1;
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      code_valid = 1'b0;
      check("illegal err pulse", 32'(err_o), 32'd1);
      check("illegal ready",     32'(code_ready), 32'd1);
      check("illegal state",     32'(state_o), 32'd0);
      check("illegal led",       32'(led_o), 32'd0);
      @(negedge CLOCK_50);
      check("illegal err clear", 32'(err_o), 32'd0);
      check("illegal state2",    32'(state_o), 32'd0);
      check("illegal led2",      32'(led_o), 32'd0);
    end

    // Back-to-back: valid never drops, so the second T transfers in the first IDLE cycle.
    code_len   = 3'd1;
    code_bits  = 5'b00001;
    code_eow   = 1'b0;
    code_valid = 1'b1;
    play("T1", 1, 5'b00001, 1'b0, 1'b1);
    play("T2", 1, 5'b00001, 1'b0, 1'b1);
    code_valid = 1'b0;
    @(negedge CLOCK_50);
    check("b2b no third", 32'(state_o), 32'd0);

    // Reset in cycle 10 of a dash.
    code_len   = 3'd1;
    code_bits  = 5'b00001;
    code_valid = 1'b1;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    code_valid = 1'b0;
    repeat (9) @(negedge CLOCK_50);
    check("pre-abort led", 32'(led_o), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("abort led",   32'(led_o), 32'd0);
    check("abort ready", 32'(code_ready), 32'd1);
    check("abort state", 32'(state_o), 32'd0);
    @(negedge CLOCK_50);
    rst = 1'b1;
    @(negedge CLOCK_50);
    check("post-abort ready", 32'(code_ready), 32'd1);
    play("E after abort", 1, 5'b00000, 1'b0, 1'b0);

    play("E eow1", 1, 5'b00000, 1'b1, 1'b0);
    play("E eow0", 1, 5'b00000, 1'b0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      len  = $urandom_range(1, ML);
      bits = ML'($urandom);
      eow  = 1'($urandom);
      play("rand", len, bits, eow, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
